// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming 2x2 / stride-2 pooling stage (average or max).
// Accepts a raster-order pixel stream, keeps one half-row of horizontal
// pair results in a line buffer and emits one pooled beat per 2x2 window
// through a single registered output slot with valid/ready backpressure.
module pool2d_stream #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 1,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic                       out_last
);

  localparam int HALF_W = IMG_W / 2;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int PAIR_W = DATA_W + 1;
  localparam int LANE_BITS = CHANNELS * DATA_W;
  localparam int PAIR_BITS = CHANNELS * PAIR_W;

  // Horizontal pair of one lane: sum (one guard bit) or zero-extended max.
  function automatic logic [PAIR_W-1:0] pair_combine(
    input logic              max_mode,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [PAIR_W-1:0] r;
    if (max_mode) begin
      if (a > b) begin
        r = {1'b0, a};
      end else begin
        r = {1'b0, b};
      end
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  // Vertical combine of two pairs: floor(sum/4) in average mode, max otherwise.
  // In max mode the pairs are zero-extended, so their low DATA_W bits suffice.
  function automatic logic [DATA_W-1:0] window_combine(
    input logic              max_mode,
    input logic [PAIR_W-1:0] top,
    input logic [PAIR_W-1:0] bot
  );
    logic [PAIR_W:0]   sum;
    logic [DATA_W-1:0] r;
    sum = {1'b0, top} + {1'b0, bot};
    if (max_mode) begin
      if (top[DATA_W-1:0] > bot[DATA_W-1:0]) begin
        r = top[DATA_W-1:0];
      end else begin
        r = bot[DATA_W-1:0];
      end
    end else begin
      r = DATA_W'(sum >> 2);
    end
    return r;
  endfunction

  // Frame position, latched mode and the held even-column pixel.
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic                 mode_q, mode_d;
  logic [LANE_BITS-1:0] hold_q, hold_d;

  // Output slot.
  logic                 out_valid_q, out_valid_d;
  logic [LANE_BITS-1:0] out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;

  // Half-row of top-row pair results; never read before written in a frame.
  logic [PAIR_BITS-1:0] lb_q [HALF_W];

  logic                 in_ready_s;
  logic                 accept_s;
  logic                 first_s;
  logic                 cur_mode_s;
  logic                 col_end_s;
  logic                 row_end_s;
  logic                 lb_we_s;
  logic                 load_s;
  logic [IDX_W-1:0]     lb_idx_s;
  logic [PAIR_BITS-1:0] lb_rd_s;
  logic [PAIR_BITS-1:0] pair_s;
  logic [LANE_BITS-1:0] result_s;

  // The output slot is the only stall point: accept input whenever it can drain.
  assign in_ready_s = !out_valid_q || out_ready;
  assign accept_s   = in_valid && in_ready_s;
  assign first_s    = (col_q == '0) && (row_q == '0);
  // The first beat of a frame already uses the mode it is latching.
  assign cur_mode_s = first_s ? mode : mode_q;
  assign col_end_s  = (col_q == COL_W'(IMG_W - 1));
  assign row_end_s  = (row_q == ROW_W'(IMG_H - 1));
  assign lb_idx_s   = IDX_W'(col_q >> 1);
  assign lb_rd_s    = lb_q[lb_idx_s];
  assign lb_we_s    = accept_s && col_q[0] && !row_q[0];
  assign load_s     = accept_s && col_q[0] && row_q[0];

  // Per-lane pair and window arithmetic for the beat currently offered.
  always_comb begin
    pair_s   = '0;
    result_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pair_s[c*PAIR_W +: PAIR_W] = pair_combine(cur_mode_s,
                                                hold_q[c*DATA_W +: DATA_W],
                                                in_data[c*DATA_W +: DATA_W]);
      result_s[c*DATA_W +: DATA_W] = window_combine(cur_mode_s,
                                                    lb_rd_s[c*PAIR_W +: PAIR_W],
                                                    pair_s[c*PAIR_W +: PAIR_W]);
    end
  end

  // Next-state for counters, frame mode and the even-column holding register.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    mode_d = mode_q;
    hold_d = hold_q;
    if (accept_s) begin
      if (first_s) begin
        mode_d = mode;
      end else begin
        mode_d = mode_q;
      end
      if (!col_q[0]) begin
        hold_d = in_data;
      end else begin
        hold_d = hold_q;
      end
      if (col_end_s) begin
        col_d = '0;
        if (row_end_s) begin
          row_d = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
        row_d = row_q;
      end
    end else begin
      col_d  = col_q;
      row_d  = row_q;
      mode_d = mode_q;
      hold_d = hold_q;
    end
  end

  // Next-state for the output slot: load wins, otherwise drain or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = result_s;
      out_last_d  = row_end_s && col_end_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer storage, written with the top-row pair on even rows.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      lb_q[lb_idx_s] <= pair_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
